// File: rtl/pix_stream_pkg.sv
// Shared types and widths for the pixel stream generator.
// PIX_STREAM_ZERO_PAD_EN (optional) zero-pads a 2-pixel border of the active area.
package pix_stream_pkg;
   localparam int COORD_W = 13;
   localparam int PIX_W   = 8;
   localparam int ADDR_W  = 19;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LINE,
      ST_HBLANK,
      ST_VBLANK
   } state_e;
endpackage

// File: rtl/raster_counter.sv
// Raster row/column counter with line and frame wrap plus terminal-count flags.
// Wraps to row=0/col=0 by itself after the last blank line's last column.
module raster_counter
   import pix_stream_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int HBLANK = 160,
   parameter int VBLANK = 45
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   output logic [COORD_W-1:0] row_o,
   output logic [COORD_W-1:0] col_o,
   output logic               act_end_o,
   output logic               line_end_o,
   output logic               last_act_row_o,
   output logic               frame_end_o
);
   localparam logic [COORD_W-1:0] COL_ACT_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] COL_LAST     = COORD_W'(WIDTH + HBLANK - 1);
   localparam logic [COORD_W-1:0] ROW_ACT_LAST = COORD_W'(HEIGHT - 1);
   localparam logic [COORD_W-1:0] ROW_LAST     = COORD_W'(HEIGHT + VBLANK - 1);

   logic [COORD_W-1:0] row_q, row_d;
   logic [COORD_W-1:0] col_q, col_d;

   assign act_end_o      = (col_q == COL_ACT_LAST);
   assign line_end_o     = (col_q == COL_LAST);
   assign last_act_row_o = (row_q == ROW_ACT_LAST);
   assign frame_end_o    = line_end_o && (row_q == ROW_LAST);
   assign row_o          = row_q;
   assign col_o          = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (en_i) begin
         if (line_end_o) begin
            col_d = '0;
            row_d = frame_end_o ? '0 : row_q + COORD_W'(1);
         end else begin
            col_d = col_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end
endmodule

// File: rtl/pix_stream_gen.sv
// Raster-order pixel streamer from a 1-cycle-latency frame RAM; outputs lag the counters by one cycle.
// Define PIX_STREAM_ZERO_PAD_EN to zero the 2-pixel border of the active area (valid unchanged).
module pix_stream_gen
   import pix_stream_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int HBLANK = 160,
   parameter int VBLANK = 45
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIX_W-1:0]   mem_q,
   output logic [PIX_W-1:0]   pix,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               valid,
   output logic               busy,
   output logic               frame_done
);
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [COORD_W-1:0]  cnt_row, cnt_col;
   logic                act_end, line_end, last_act_row, frame_end;
   logic [COORD_W-1:0]  row_q, col_q;
   logic                valid_q, busy_q, done_q;
   logic                busy_d, done_d;

   raster_counter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .HBLANK(HBLANK),
      .VBLANK(VBLANK)
   ) u_cnt (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (state_q != ST_IDLE),
      .row_o         (cnt_row),
      .col_o         (cnt_col),
      .act_end_o     (act_end),
      .line_end_o    (line_end),
      .last_act_row_o(last_act_row),
      .frame_end_o   (frame_end)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LINE;
               addr_d  = '0;
            end
         end
         ST_LINE: begin
            addr_d = addr_q + ADDR_W'(1);
            if (act_end) state_d = ST_HBLANK;
         end
         ST_HBLANK: begin
            if (line_end) state_d = last_act_row ? ST_VBLANK : ST_LINE;
         end
         ST_VBLANK: begin
            // Final count: start chains straight into the next frame.
            if (frame_end) begin
               if (start) begin
                  state_d = ST_LINE;
                  addr_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // frame_done keeps busy high for one extra cycle after the counters stop.
   assign done_d = (state_q == ST_VBLANK) && frame_end;
   assign busy_d = (state_d != ST_IDLE) || done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= cnt_row;
         col_q   <= cnt_col;
         valid_q <= (state_q == ST_LINE);
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef PIX_STREAM_ZERO_PAD_EN
   logic pad_q, pad_d;

   assign pad_d = (cnt_row < COORD_W'(2)) || (cnt_row >= COORD_W'(HEIGHT - 2)) ||
                  (cnt_col < COORD_W'(2)) || (cnt_col >= COORD_W'(WIDTH - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pad_q <= 1'b0;
      else     pad_q <= pad_d;
   end

   assign pix = (valid_q && !pad_q) ? mem_q : '0;
`else
   // mem_q already lags mem_addr by one cycle, matching the registered coordinates.
   assign pix = valid_q ? mem_q : '0;
`endif

   assign mem_addr   = addr_q;
   assign row        = row_q;
   assign col        = col_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule
